// File: rtl/lcd_fb_writer_pkg.sv
// Shared LCD geometry, framebuffer entry layout and pixel-packing helpers
// for the framebuffer writer and its neighbours.
package lcd_fb_writer_pkg;

    localparam int LCD_W_DEF      = 160;
    localparam int LCD_H_DEF      = 144;
    localparam int WORDS_PER_LINE = LCD_W_DEF / 8;
    localparam int FB_IDX_W       = 12;
    localparam int ADDR_W         = 1 + FB_IDX_W;
    localparam int FIFO_DEPTH_DEF = 4;

    localparam logic [1:0] FLIP_IDLE    = 2'd0;
    localparam logic [1:0] FLIP_PENDING = 2'd1;
    localparam logic [1:0] FLIP_FIRE    = 2'd2;

    typedef struct packed {
        logic                page;
        logic [FB_IDX_W-1:0] idx;
        logic [15:0]         data;
    } fb_entry_t;

    // Pixel n of a word lives in bits [2n+1:2n].
    function automatic logic [15:0] pack_pixel(input logic [15:0] acc,
                                               input logic [2:0]  slot,
                                               input logic [1:0]  col);
        logic [15:0] r;
        r = acc;
        r[{slot, 1'b0} +: 2] = col;
        return r;
    endfunction

    function automatic logic [FB_IDX_W-1:0] word_index(input logic [7:0] y,
                                                       input logic [7:0] x,
                                                       input int         wpl);
        return FB_IDX_W'((int'(y) * wpl) + int'(x[7:3]));
    endfunction

endpackage

// File: rtl/lcd_fb_writer_if.sv
// Framebuffer RAM write port: the writer is the master, the RAM the slave.
interface lcd_fb_writer_if;
    import lcd_fb_writer_pkg::*;

    // mem_req is the valid, mem_ack the ready: a transfer happens on every
    // cycle where both are high, and addr/wdata hold steady while req waits.
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              mem_ack;

    modport master (output mem_req, output mem_addr, output mem_wdata, input mem_ack);
    modport slave  (input mem_req, input mem_addr, input mem_wdata, output mem_ack);
endinterface

// File: rtl/lcd_fb_writer_fb_fifo.sv
// Small synchronous FIFO; a push into a full FIFO succeeds only when a pop
// frees a slot in the same cycle.
module fb_fifo #(
    parameter int WIDTH = 29,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic             push_en, pop_en;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]) && (wr_ptr_q[PW] != rd_ptr_q[PW]);
        pop_en   = pop && !empty;
        push_en  = push && (!full || pop_en);
        wr_ptr_d = wr_ptr_q + (PW+1)'(push_en);
        rd_ptr_d = rd_ptr_q + (PW+1)'(pop_en);
        mem_d    = mem_q;
        if (push_en) mem_d[wr_ptr_q[PW-1:0]] = din;
        dout     = mem_q[rd_ptr_q[PW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/lcd_fb_writer.sv
// Packs the PPU pixel stream into 16-bit words, queues them and writes them
// into a double-buffered framebuffer, flipping pages once per frame.
module lcd_fb_writer
    import lcd_fb_writer_pkg::*;
#(
    parameter int LCD_W      = LCD_W_DEF,
    parameter int LCD_H      = LCD_H_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    lcd_write,
    input  logic [1:0]              lcd_col,
    input  logic [7:0]              lcd_x,
    input  logic [7:0]              lcd_y,
    input  logic                    lcd_vblank,
    lcd_fb_writer_if.master         mem,
    output logic                    fb_page,
    output logic                    frame_done,
    output logic                    overflow,
    output logic [1:0]              dbg_flip_state
);
    localparam logic [8:0] X_LIM = 9'(LCD_W);
    localparam logic [8:0] Y_LIM = 9'(LCD_H);
    localparam int         WPL   = LCD_W / 8;

    logic [15:0] acc_q, acc_d;
    logic        fb_page_q, fb_page_d;
    logic        overflow_q, overflow_d;
    logic        vblank_q, vblank_d;
    logic [1:0]  flip_state_q, flip_state_d;

    logic        pix_ok, push, pop, vblank_rise, flip_fire;
    logic        fifo_full, fifo_empty;
    fb_entry_t   push_entry, head;

    always_comb begin
        pix_ok = lcd_write && ({1'b0, lcd_x} < X_LIM) && ({1'b0, lcd_y} < Y_LIM);
        acc_d  = acc_q;
        if (pix_ok) acc_d = pack_pixel(acc_q, lcd_x[2:0], lcd_col);
        // The pushed word already carries the pixel arriving this cycle.
        push       = pix_ok && (lcd_x[2:0] == 3'd7);
        push_entry = '{page: fb_page_q, idx: word_index(lcd_y, lcd_x, WPL), data: acc_d};
        pop        = !fifo_empty && mem.mem_ack;
        overflow_d = overflow_q | (push && fifo_full && !pop);
    end

    always_comb begin
        vblank_d     = lcd_vblank;
        vblank_rise  = lcd_vblank && !vblank_q;
        flip_fire    = (flip_state_q == FLIP_PENDING) && fifo_empty;
        flip_state_d = flip_state_q;
        case (flip_state_q)
            FLIP_IDLE:    if (vblank_rise) flip_state_d = FLIP_PENDING;
            FLIP_PENDING: if (fifo_empty)  flip_state_d = FLIP_IDLE;
            default:                       flip_state_d = FLIP_IDLE;
        endcase
        fb_page_d = fb_page_q ^ flip_fire;
    end

    fb_fifo #(
        .WIDTH ($bits(fb_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (push_entry),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // vblank_q keeps tracking through reset so a high vblank at release is not a rise.
    always_ff @(posedge clk) begin
        vblank_q <= vblank_d;
        if (reset) begin
            acc_q        <= '0;
            fb_page_q    <= 1'b0;
            overflow_q   <= 1'b0;
            flip_state_q <= FLIP_IDLE;
        end else begin
            acc_q        <= acc_d;
            fb_page_q    <= fb_page_d;
            overflow_q   <= overflow_d;
            flip_state_q <= flip_state_d;
        end
    end

    assign mem.mem_req   = !fifo_empty;
    assign mem.mem_addr  = fifo_empty ? '0 : {head.page, head.idx};
    assign mem.mem_wdata = fifo_empty ? '0 : head.data;

    assign fb_page        = fb_page_q;
    assign frame_done     = flip_fire;
    assign overflow       = overflow_q;
    assign dbg_flip_state = flip_fire ? FLIP_FIRE : flip_state_q;

endmodule
